// File: rtl/uart_rx_ext_if.sv
// rtl/uart_rx_ext_if.sv - received-word valid/ready handshake and status of uart_rx_ext
interface uart_rx_ext_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_overrun;
    logic                 o_busy;

    modport master (
        output o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy,
        input  i_ready
    );

    modport slave (
        input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_ext.sv
// rtl/uart_rx_ext.sv - parametrised UART receiver with valid/ready word register
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, one cycle later.
module uart_rx_ext #(
    parameter int CLK_FREQ  = 250000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_in,
    uart_rx_ext_if.master rx_if
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB) + 1;
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT   = CW'(CPB - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t               state, state_n;
    logic                 sync1, rx;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_err, par_err_n;
    logic                 frm_err, frm_err_n;
    logic                 armed, armed_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 perr_q, perr_n;
    logic                 ferr_q, ferr_n;
    logic                 ovr_q, ovr_n;
    logic                 sampling, at_point, strobe, bit_val;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= i_in;
            rx    <= sync1;
        end
    end

    assign sampling = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP);
    assign at_point = sampling && (cnt == '0);

`ifdef UART_RX_MAJORITY_EN
    // Decision is taken one edge after the sample point, once the +1 sample exists.
    logic rx_d1, rx_d2, point_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_d1   <= 1'b1;
            rx_d2   <= 1'b1;
            point_d <= 1'b0;
        end else begin
            rx_d1   <= rx;
            rx_d2   <= rx_d1;
            point_d <= at_point;
        end
    end

    assign strobe  = point_d;
    assign bit_val = (rx & rx_d1) | (rx & rx_d2) | (rx_d1 & rx_d2);
`else
    assign strobe  = at_point;
    assign bit_val = rx;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            armed   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par_err <= par_err_n;
            frm_err <= frm_err_n;
            armed   <= armed_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            perr_q  <= perr_n;
            ferr_q  <= ferr_n;
            ovr_q   <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        par_err_n = par_err;
        frm_err_n = frm_err;
        armed_n   = armed | rx;
        data_n    = data_q;
        perr_n    = perr_q;
        ferr_n    = 1'b0;
        ovr_n     = 1'b0;
        valid_n   = valid_q & ~rx_if.i_ready;

        if (sampling) begin
            cnt_n = (cnt == '0) ? CNT_BIT : cnt - CW'(1);
        end

        case (state)
            S_IDLE: begin
                if (armed && !rx) begin
                    cnt_n   = CNT_HALF;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (strobe) begin
                    if (bit_val) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n   = S_DATA;
                        idx_n     = '0;
                        par_err_n = 1'b0;
                        frm_err_n = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (strobe) begin
                    // LSB arrives first, so after DATA_BITS right shifts it sits at bit 0.
                    shreg_n = {bit_val, shreg[DATA_BITS-1:1]};
                    if (idx == LAST_DATA) begin
                        idx_n   = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (strobe) begin
                    par_err_n = (((^shreg) ^ bit_val) != PAR_ODD);
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (strobe) begin
                    if (!bit_val) begin
                        frm_err_n = 1'b1;
                    end
                    if (idx == LAST_STOP) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                if (frm_err) begin
                    ferr_n  = 1'b1;
                    armed_n = 1'b0;
                end else if (valid_q && !rx_if.i_ready) begin
                    ovr_n = 1'b1;
                end else begin
                    data_n  = shreg;
                    perr_n  = par_err;
                    valid_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign rx_if.o_data       = data_q;
    assign rx_if.o_valid      = valid_q;
    assign rx_if.o_parity_err = perr_q;
    assign rx_if.o_frame_err  = ferr_q;
    assign rx_if.o_overrun    = ovr_q;
    assign rx_if.o_busy       = (state != S_IDLE);
endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver; successor to the fixed 8/N/1 receiver. Adds configurable data width, parity and stop bits, an input synchroniser, false-start rejection, and framing and parity error reporting. Received words are held in a valid/ready output register with overrun detection. Sits between the `i_in` pad and the character-processing pipeline, which consumes words at its own pace.

## Interface
- `CLK_FREQ`, default 250000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. `CPB = CLK_FREQ / BAUD` (integer division); `HALF = CPB / 2`. `CPB` must be ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_in`  in  1  serial line, idle high, asynchronous to `i_clk`.
- `i_ready`  in  1  consumer accepts `o_data` in a cycle where `o_valid && i_ready`.
- `o_data`  out  `DATA_BITS`  received word, LSB first on the line; stable while `o_valid`.
- `o_valid`  out  1  word available; held until accepted.
- `o_parity_err`  out  1  parity mismatch for the word in `o_data`; meaningful only with `o_valid`.
- `o_frame_err`  out  1  one-cycle pulse: a stop bit was sampled low; the word is discarded.
- `o_overrun`  out  1  one-cycle pulse: a frame completed while `o_valid && !i_ready`; the new word is discarded.
- `o_busy`  out  1  FSM not in IDLE.

## Operation
- **Synchroniser.** `i_in` passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised signal `rx`.
- **Counter.** Down-counter of width `$clog2(CPB)+1`. A bit is sampled when the counter reaches 0, after which the counter reloads `CPB-1`.
- **IDLE.**
  - Start detection is armed only after `rx` has been seen high at least once since reset or since the last frame error.
  - When armed and `rx == 0`: load the counter with `HALF-1` and go to START.
- **START.** At the sample point: if `rx == 1` it is a false start → IDLE with no output. Otherwise → DATA with bit index 0.
- **DATA.**
  - Each sample shifts into bit[index].
  - After bit `DATA_BITS-1` → PARITY if `PARITY != 0`, else STOP.
- **PARITY.** Sample the parity bit. Error if (XOR of data ^ sampled bit) is not 1 for odd parity or not 0 for even parity.
- **STOP.**
  - Sample `STOP_BITS` bits. Any low sample sets frame error.
  - On the last stop sample: if frame error, pulse `o_frame_err`, disarm start detection, and go to IDLE.
  - Else if `o_valid && !i_ready`: pulse `o_overrun` and keep the old word.
  - Else load `o_data`/`o_parity_err`, set `o_valid`, and go to IDLE.
- **Acceptance and reload.** Acceptance (`o_valid && i_ready`) clears `o_valid` next cycle. If acceptance and frame completion fall in the same cycle, the word is accepted and the new word loads; `o_valid` stays 1 and no overrun is flagged.
- **Reset values.** On reset (any time, mid-frame included): FSM to IDLE, start detection disarmed, counter = 0, and all outputs 0: `o_data`, `o_valid`, `o_parity_err`, `o_frame_err`, `o_overrun`, `o_busy`.

## Timing
- Let t0 be the edge at which the pad low is first captured.
  - IDLE sees `rx == 0` at edge t0+2.
  - The start bit is sampled at t0+2+HALF.
  - Frame bit k (k = 1 … `DATA_BITS+P+STOP_BITS`, where P = 1 if parity is enabled) is sampled at t0+2+HALF+k·CPB.
- `o_valid` (or `o_frame_err`/`o_overrun`) is registered at the edge after the last stop sample.
  - Default configuration (8N1, CPB = 26): `o_valid` goes high at edge t0+250.
- Back-to-back frames: IDLE re-arms on the cycle after the last stop sample. A start edge arriving half a bit after the stop centre is caught.
- Error pulses are exactly one cycle wide.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit (start, data, parity, stop) is the 2-of-3 majority of `rx` sampled at sample point −1, 0 and +1.
  - The decision is made at sample point +1, so all outputs arrive one cycle later than without the macro.
- Not defined: a single sample at the sample point; timing exactly as stated above.

## Test plan
- **8N1 basic.** Send 0xA5 with stop bit high, `i_ready=1` → `o_valid` pulses 1 cycle at t0+250 with `o_data=0xA5` and `o_parity_err=0`.
- **Even parity, 7 data bits.** Configure `DATA_BITS=7`, `PARITY=2`. Send 0x41 with parity bit 1 → `o_data=0x41`, `o_parity_err=1`. Resend with parity bit 0 → `o_parity_err=0`.
- **False start and framing error.**
  - Drive `i_in` low for 5 clocks → no output, `o_busy` returns to 0 by t0+2+HALF+1.
  - Send 0x3C with stop bit low → `o_frame_err` one-cycle pulse, `o_valid` stays 0.
  - A following valid 0x55 is received only after the line returns high.
- **Overrun.**
  - With `i_ready=0`, send 0x11 then 0x22 → `o_valid=1` with `o_data=0x11`; `o_overrun` pulses at the end of the second frame.
  - Raise `i_ready` → 0x11 is accepted and `o_valid` drops.
- **Simultaneous accept and complete, then reset.**
  - With 0x11 pending, assert `i_ready` exactly on the completion cycle of 0x22 → `o_data=0x22`, `o_valid` stays 1, no overrun.
  - Assert `i_rst` mid-frame at bit 4 → all outputs 0 immediately; no word is delivered from the partial frame.
- **Majority vote (with `UART_RX_MAJORITY_EN`).** Inject a 1-clock glitch at the centre of data bit 3 of 0x00 → `o_data=0x00`, `o_valid` at t0+251.
